// File: rtl/fifo_out_rd_ctrl.sv
// Read-side controller for the 32x32 FIFO_OUT register file: pointers, occupancy, flags and registered pop data.
// Optional error pulses on rd_err/wr_err are built only when FIFO_OUT_ERR_EN is defined.
module fifo_out_rd_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] d_in0,
  input  logic [31:0] d_in1,
  input  logic [31:0] d_in2,
  input  logic [31:0] d_in3,
  input  logic [31:0] d_in4,
  input  logic [31:0] d_in5,
  input  logic [31:0] d_in6,
  input  logic [31:0] d_in7,
  input  logic [31:0] d_in8,
  input  logic [31:0] d_in9,
  input  logic [31:0] d_in10,
  input  logic [31:0] d_in11,
  input  logic [31:0] d_in12,
  input  logic [31:0] d_in13,
  input  logic [31:0] d_in14,
  input  logic [31:0] d_in15,
  input  logic [31:0] d_in16,
  input  logic [31:0] d_in17,
  input  logic [31:0] d_in18,
  input  logic [31:0] d_in19,
  input  logic [31:0] d_in20,
  input  logic [31:0] d_in21,
  input  logic [31:0] d_in22,
  input  logic [31:0] d_in23,
  input  logic [31:0] d_in24,
  input  logic [31:0] d_in25,
  input  logic [31:0] d_in26,
  input  logic [31:0] d_in27,
  input  logic [31:0] d_in28,
  input  logic [31:0] d_in29,
  input  logic [31:0] d_in30,
  input  logic [31:0] d_in31,
  input  logic        wr_push,
  input  logic        rd_en,
  output logic [4:0]  wr_ptr,
  output logic [31:0] d_out,
  output logic        rd_ack,
  output logic        empty,
  output logic        full,
  output logic [5:0]  data_count,
  output logic        rd_err,
  output logic        wr_err
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_NORMAL = 2'b01,
    ST_FULL   = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  wr_ptr_q, wr_ptr_d;
  logic [4:0]  rd_ptr_q, rd_ptr_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] d_out_q, d_out_d;
  logic        rd_ack_q, rd_ack_d;
  logic        empty_q, empty_d;
  logic        full_q, full_d;
  logic        push_ok, pop_ok, illegal_st;
  logic [31:0] d_in_s [0:31];

  assign d_in_s[0]  = d_in0;
  assign d_in_s[1]  = d_in1;
  assign d_in_s[2]  = d_in2;
  assign d_in_s[3]  = d_in3;
  assign d_in_s[4]  = d_in4;
  assign d_in_s[5]  = d_in5;
  assign d_in_s[6]  = d_in6;
  assign d_in_s[7]  = d_in7;
  assign d_in_s[8]  = d_in8;
  assign d_in_s[9]  = d_in9;
  assign d_in_s[10] = d_in10;
  assign d_in_s[11] = d_in11;
  assign d_in_s[12] = d_in12;
  assign d_in_s[13] = d_in13;
  assign d_in_s[14] = d_in14;
  assign d_in_s[15] = d_in15;
  assign d_in_s[16] = d_in16;
  assign d_in_s[17] = d_in17;
  assign d_in_s[18] = d_in18;
  assign d_in_s[19] = d_in19;
  assign d_in_s[20] = d_in20;
  assign d_in_s[21] = d_in21;
  assign d_in_s[22] = d_in22;
  assign d_in_s[23] = d_in23;
  assign d_in_s[24] = d_in24;
  assign d_in_s[25] = d_in25;
  assign d_in_s[26] = d_in26;
  assign d_in_s[27] = d_in27;
  assign d_in_s[28] = d_in28;
  assign d_in_s[29] = d_in29;
  assign d_in_s[30] = d_in30;
  assign d_in_s[31] = d_in31;

  // Acceptance of push/pop in each state; in FULL a push rides on a simultaneous pop.
  always_comb begin
    push_ok    = 1'b0;
    pop_ok     = 1'b0;
    illegal_st = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        push_ok = wr_push;
        pop_ok  = 1'b0;
      end
      ST_NORMAL: begin
        push_ok = wr_push;
        pop_ok  = rd_en;
      end
      ST_FULL: begin
        push_ok = wr_push & rd_en;
        pop_ok  = rd_en;
      end
      default: begin
        push_ok    = 1'b0;
        pop_ok     = 1'b0;
        illegal_st = 1'b1;
      end
    endcase
  end

  // Next pointers, count, data and flags; the unused state code drops back to a clean empty FIFO.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    d_out_d  = d_out_q;
    rd_ack_d = pop_ok;
    state_d  = ST_EMPTY;

    if (illegal_st) begin
      count_d  = 6'd0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      count_d = count_q + {5'd0, push_ok} - {5'd0, pop_ok};
    end

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 5'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 5'd1;
      d_out_d  = d_in_s[rd_ptr_q];
    end else begin
      d_out_d  = d_out_q;
    end

    if (count_d == 6'd0) begin
      state_d = ST_EMPTY;
    end else if (count_d == 6'd32) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_NORMAL;
    end

    empty_d = (count_d == 6'd0);
    full_d  = (count_d == 6'd32);
  end

  // State, pointer, count and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= 5'd0;
      rd_ptr_q <= 5'd0;
      count_q  <= 6'd0;
      d_out_q  <= 32'd0;
      rd_ack_q <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      d_out_q  <= d_out_d;
      rd_ack_q <= rd_ack_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign wr_ptr     = wr_ptr_q;
  assign d_out      = d_out_q;
  assign rd_ack     = rd_ack_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign data_count = count_q;

`ifdef FIFO_OUT_ERR_EN
  logic rd_err_q, wr_err_q;
  logic rd_rej, wr_rej;

  assign rd_rej = rd_en & ~pop_ok;
  assign wr_rej = wr_push & ~push_ok;

  // One-cycle pulses for rejected requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      rd_err_q <= rd_rej;
      wr_err_q <= wr_rej;
    end
  end

  assign rd_err = rd_err_q;
  assign wr_err = wr_err_q;
`else
  assign rd_err = 1'b0;
  assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_out_rd_ctrl.sv
// Self-checking bench for fifo_out_rd_ctrl: queue-based reference model, emulated register file,
// directed corner cases plus randomized push/pop traffic.
module tb_fifo_out_rd_ctrl;

`ifdef FIFO_OUT_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_push, rd_en;
  logic [31:0] mem [32];
  logic [4:0]  wr_ptr;
  logic [31:0] d_out;
  logic        rd_ack, empty, full, rd_err, wr_err;
  logic [5:0]  data_count;

  always #5 clk = ~clk;

  fifo_out_rd_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .d_in0(mem[0]),   .d_in1(mem[1]),   .d_in2(mem[2]),   .d_in3(mem[3]),
    .d_in4(mem[4]),   .d_in5(mem[5]),   .d_in6(mem[6]),   .d_in7(mem[7]),
    .d_in8(mem[8]),   .d_in9(mem[9]),   .d_in10(mem[10]), .d_in11(mem[11]),
    .d_in12(mem[12]), .d_in13(mem[13]), .d_in14(mem[14]), .d_in15(mem[15]),
    .d_in16(mem[16]), .d_in17(mem[17]), .d_in18(mem[18]), .d_in19(mem[19]),
    .d_in20(mem[20]), .d_in21(mem[21]), .d_in22(mem[22]), .d_in23(mem[23]),
    .d_in24(mem[24]), .d_in25(mem[25]), .d_in26(mem[26]), .d_in27(mem[27]),
    .d_in28(mem[28]), .d_in29(mem[29]), .d_in30(mem[30]), .d_in31(mem[31]),
    .wr_push(wr_push), .rd_en(rd_en), .wr_ptr(wr_ptr), .d_out(d_out),
    .rd_ack(rd_ack), .empty(empty), .full(full), .data_count(data_count),
    .rd_err(rd_err), .wr_err(wr_err)
  );

  // Reference model: contents as a queue, writer pointer as a plain counter.
  logic [31:0] q [$];
  logic [4:0]  m_wr;
  logic [31:0] exp_dout;
  logic        exp_ack, exp_rerr, exp_werr;
  bit          chk_en = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("d_out",      d_out,                exp_dout);
      check("rd_ack",     32'(rd_ack),          32'(exp_ack));
      check("rd_err",     32'(rd_err),          32'(exp_rerr));
      check("wr_err",     32'(wr_err),          32'(exp_werr));
      check("wr_ptr",     32'(wr_ptr),          32'(m_wr));
      check("data_count", 32'(data_count),      32'(q.size()));
      check("empty",      32'(empty),           32'(q.size() == 0));
      check("full",       32'(full),            32'(q.size() == 32));
    end
  end

  // One clock of stimulus; model and register file follow the same acceptance rules.
  task automatic step(input bit push, input bit pop, input logic [31:0] data);
    bit pa, pp;
    int n;
    logic [4:0] waddr;
    wr_push = push;
    rd_en   = pop;
    @(posedge clk);
    n  = q.size();
    pp = pop && (n > 0);
    pa = push && ((n < 32) || pp);
    exp_ack  = pp;
    exp_rerr = ERR_ON && pop && !pp;
    exp_werr = ERR_ON && push && !pa;
    waddr = m_wr;
    if (pp) exp_dout = q.pop_front();
    if (pa) begin
      q.push_back(data);
      m_wr = m_wr + 5'd1;
    end
    #1;
    if (pa) mem[waddr] = data;
    @(negedge clk);
    wr_push = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_empty",  32'(empty),      32'd1);
    check("rst_full",   32'(full),       32'd0);
    check("rst_count",  32'(data_count), 32'd0);
    check("rst_dout",   d_out,           32'd0);
    check("rst_wr_ptr", 32'(wr_ptr),     32'd0);
    check("rst_ack",    32'(rd_ack),     32'd0);
    q.delete();
    m_wr     = 5'd0;
    exp_dout = 32'd0;
    exp_ack  = 1'b0;
    exp_rerr = 1'b0;
    exp_werr = 1'b0;
    wr_push  = 1'b0;
    rd_en    = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int thr;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    reset_n  = 1'b0;
    wr_push  = 1'b0;
    rd_en    = 1'b0;
    m_wr     = 5'd0;
    exp_dout = 32'd0;
    exp_ack  = 1'b0;
    exp_rerr = 1'b0;
    exp_werr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset mid-stream with five words held, then pop on empty.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'h100 + 32'(k));
    check("pre_rst_count", 32'(data_count), 32'd5);
    do_reset();
    step(1'b0, 1'b1, 32'd0);
    check("post_rst_rd_err", 32'(rd_err), 32'(ERR_ON));
    check("post_rst_ack",    32'(rd_ack), 32'd0);

    // Single word through entry 0.
    step(1'b1, 1'b0, 32'h0000_0078);
    step(1'b0, 1'b1, 32'd0);
    check("sw_dout",  d_out,                32'h0000_0078);
    check("sw_ack",   32'(rd_ack),          32'd1);
    check("sw_empty", 32'(empty),           32'd1);
    check("sw_count", 32'(data_count),      32'd0);

    // Fill, overflow, then drain with wrap.
    do_reset();
    for (int k = 0; k < 32; k++) step(1'b1, 1'b0, 32'(k));
    check("fill_full",  32'(full),       32'd1);
    check("fill_count", 32'(data_count), 32'd32);
    step(1'b1, 1'b0, 32'hDEAD_BEEF);
    check("ovf_wr_err", 32'(wr_err), 32'(ERR_ON));
    check("ovf_wr_ptr", 32'(wr_ptr), 32'd0);
    check("ovf_count",  32'(data_count), 32'd32);
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 1'b1, 32'd0);
      check("drain_dout", d_out,       32'(k));
      check("drain_ack",  32'(rd_ack), 32'd1);
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Full with simultaneous push and pop on the shared entry.
    for (int k = 0; k < 32; k++) step(1'b1, 1'b0, (k == 0) ? 32'hAAAA_AAAA : 32'(k));
    step(1'b1, 1'b1, 32'h5555_5555);
    check("fsim_dout",   d_out,       32'hAAAA_AAAA);
    check("fsim_full",   32'(full),   32'd1);
    check("fsim_wr_ptr", 32'(wr_ptr), 32'd1);
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 32'd0);
    check("fsim_last", d_out, 32'h5555_5555);

    // Empty with simultaneous push and pop.
    step(1'b1, 1'b1, 32'h1234_5678);
    check("esim_rd_err", 32'(rd_err),     32'(ERR_ON));
    check("esim_ack",    32'(rd_ack),     32'd0);
    check("esim_count",  32'(data_count), 32'd1);
    step(1'b0, 1'b1, 32'd0);
    check("esim_dout",   d_out,           32'h1234_5678);

    // Randomized traffic in phases biased toward fill, drain and balance.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 150) % 3)
        0:       thr = 75;
        1:       thr = 25;
        default: thr = 50;
      endcase
      if (i == 1700) do_reset();
      step(($urandom_range(99) < thr), ($urandom_range(99) < (100 - thr)), $urandom);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
